// File: rtl/systolic_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module  : systolic_operand_feeder
// Brief   : Buffers A (ROWS x K) then B (K x COLS) from one stream and feeds an
//           output-stationary systolic array with skewed, zero-padded operands.
// Revision: 1.0 - initial release
// ============================================================================
module systolic_operand_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int K            = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       start,
    input  logic                       keep_b,
    output logic                       busy,
    output logic                       acc_clear,
    output logic [ROWS*DATA_WIDTH-1:0] a_out,
    output logic [ROWS-1:0]            a_valid,
    output logic [COLS*DATA_WIDTH-1:0] b_out,
    output logic [COLS-1:0]            b_valid,
    output logic                       done
);
    localparam int A_N    = ROWS * K;
    localparam int B_N    = K * COLS;
    localparam int T_FEED = K + ((ROWS > COLS) ? ROWS : COLS) - 1;
    localparam int PH_MAX = (T_FEED > DRAIN_CYCLES) ? T_FEED : DRAIN_CYCLES;
    localparam int CNT_W  = $clog2(A_N + B_N + 1);
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int AW     = (A_N > 1) ? $clog2(A_N) : 1;
    localparam int BW     = (B_N > 1) ? $clog2(B_N) : 1;

    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_LOADED = 3'd1;
    localparam logic [2:0] S_CLR    = 3'd2;
    localparam logic [2:0] S_FEED   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [CNT_W-1:0] LEN_A      = CNT_W'(A_N);
    localparam logic [CNT_W-1:0] LEN_AB     = CNT_W'(A_N + B_N);
    localparam logic [PH_W-1:0]  FEED_LAST  = PH_W'(T_FEED - 1);
    localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);

    logic [2:0]                state, next_state;
    logic [PH_W-1:0]           phase, phase_d;
    logic [CNT_W-1:0]          cnt, load_len;
    logic                      keep_flag, accept, load_last;
    logic                      in_ready_d, busy_d, acc_clear_d, done_d, feed_d;
    logic [ROWS*DATA_WIDTH-1:0] a_nxt;
    logic [ROWS-1:0]           av_nxt;
    logic [COLS*DATA_WIDTH-1:0] b_nxt;
    logic [COLS-1:0]           bv_nxt;
    logic [DATA_WIDTH-1:0]     a_mem [A_N];
    logic [DATA_WIDTH-1:0]     b_mem [B_N];

    assign accept    = in_valid && in_ready && !clear;
    assign load_len  = keep_flag ? LEN_A : LEN_AB;
    assign load_last = (cnt == load_len - 1'b1);

    // Operand buffers hold their contents across reset and clear.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (cnt < LEN_A) a_mem[AW'(cnt)] <= in_data;
            else             b_mem[BW'(cnt - LEN_A)] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            keep_flag <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            keep_flag <= 1'b0;
        end else begin
            if (accept)                     cnt       <= load_last ? '0 : cnt + 1'b1;
            if (state == S_LOADED && start) keep_flag <= keep_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            phase     <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            acc_clear <= 1'b0;
            done      <= 1'b0;
            a_out     <= '0;
            a_valid   <= '0;
            b_out     <= '0;
            b_valid   <= '0;
        end else begin
            state     <= next_state;
            phase     <= phase_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            acc_clear <= acc_clear_d;
            done      <= done_d;
            a_out     <= a_nxt;
            a_valid   <= av_nxt;
            b_out     <= b_nxt;
            b_valid   <= bv_nxt;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = S_LOAD;
        end else begin
            case (state)
                S_LOAD:   if (accept && load_last) next_state = S_LOADED;
                S_LOADED: if (start) next_state = S_CLR;
                S_CLR:    next_state = S_FEED;
                S_FEED:   if (phase == FEED_LAST)
                              next_state = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                S_DRAIN:  if (phase == DRAIN_LAST) next_state = S_DONE;
                S_DONE:   next_state = S_LOAD;
                default:  next_state = S_LOAD;
            endcase
        end
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        in_ready_d  = (next_state == S_LOAD);
        acc_clear_d = (next_state == S_CLR);
        busy_d      = (next_state == S_CLR) || (next_state == S_FEED) || (next_state == S_DRAIN);
        done_d      = (next_state == S_DONE);
        feed_d      = (next_state == S_FEED);
        phase_d     = '0;
        if ((next_state == state) && (state == S_FEED || state == S_DRAIN))
            phase_d = phase + 1'b1;
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        localparam logic [PH_W-1:0] ROW_OFS  = PH_W'(i);
        localparam logic [AW-1:0]   ROW_BASE = AW'(i * K);
        logic [PH_W:0] diff;
        logic          hit;
        // Borrow bit flags t < i, i.e. this row has not started yet.
        assign diff  = {1'b0, phase_d} - {1'b0, ROW_OFS};
        assign hit   = feed_d && !diff[PH_W] && (diff[PH_W-1:0] < PH_W'(K));
        assign av_nxt[i] = hit;
        assign a_nxt[i*DATA_WIDTH +: DATA_WIDTH] =
            hit ? a_mem[ROW_BASE + AW'(diff[PH_W-1:0])] : '0;
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam logic [PH_W-1:0] COL_OFS = PH_W'(j);
        logic [PH_W:0] diff;
        logic          hit;
        assign diff  = {1'b0, phase_d} - {1'b0, COL_OFS};
        assign hit   = feed_d && !diff[PH_W] && (diff[PH_W-1:0] < PH_W'(K));
        assign bv_nxt[j] = hit;
        assign b_nxt[j*DATA_WIDTH +: DATA_WIDTH] =
            hit ? b_mem[BW'(diff[PH_W-1:0]) * BW'(COLS) + BW'(j)] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_operand_feeder
// Brief   : Scoreboard bench for the default 4x4 feeder and a 2x3, K=5 variant.
// Revision: 1.0 - initial release
// ============================================================================
module tb_systolic_operand_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clear, in_v, start_r, keep_b, sel;
    logic [7:0] in_data;

    logic        in_ready0, busy0, acc0, done0;
    logic [31:0] a0, b0;
    logic [3:0]  av0, bv0;
    logic        in_ready1, busy1, acc1, done1;
    logic [15:0] a1;
    logic [23:0] b1;
    logic [1:0]  av1;
    logic [2:0]  bv1;

    systolic_operand_feeder u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_v & ~sel),
        .in_ready(in_ready0), .in_data(in_data), .start(start_r & ~sel),
        .keep_b(keep_b), .busy(busy0), .acc_clear(acc0), .a_out(a0),
        .a_valid(av0), .b_out(b0), .b_valid(bv0), .done(done0));

    systolic_operand_feeder #(.DATA_WIDTH(8), .ROWS(2), .COLS(3), .K(5), .DRAIN_CYCLES(8)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_v & sel),
        .in_ready(in_ready1), .in_data(in_data), .start(start_r & sel),
        .keep_b(keep_b), .busy(busy1), .acc_clear(acc1), .a_out(a1),
        .a_valid(av1), .b_out(b1), .b_valid(bv1), .done(done1));

    logic [63:0] oa, ob;
    logic [7:0]  oav, obv;
    logic        ordy;
    logic [2:0]  ctl;  // {acc_clear, done, busy}
    assign oa   = sel ? 64'(a1)  : 64'(a0);
    assign ob   = sel ? 64'(b1)  : 64'(b0);
    assign oav  = sel ? 8'(av1)  : 8'(av0);
    assign obv  = sel ? 8'(bv1)  : 8'(bv0);
    assign ordy = sel ? in_ready1 : in_ready0;
    assign ctl  = sel ? {acc1, done1, busy1} : {acc0, done0, busy0};

    typedef struct packed {
        logic [63:0] a;
        logic [7:0]  av;
        logic [63:0] b;
        logic [7:0]  bv;
    } feed_t;

    feed_t      exp_q[$];
    logic [7:0] am [32];
    logic [7:0] bm [32];
    logic [7:0] stream [32];
    int R = 4, C = 4, KK = 4, D = 8;
    int n_checks = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_expect();
        int    t_feed = KK + ((R > C) ? R : C) - 1;
        int    d;
        feed_t e;
        for (int t = 0; t < t_feed + D; t++) begin
            e = '0;
            if (t < t_feed) begin
                for (int i = 0; i < R; i++) begin
                    d = t - i;
                    if (d >= 0 && d < KK) begin
                        e.a[i*8 +: 8] = am[i*KK + d];
                        e.av[i] = 1'b1;
                    end
                end
                for (int j = 0; j < C; j++) begin
                    d = t - j;
                    if (d >= 0 && d < KK) begin
                        e.b[j*8 +: 8] = bm[d*C + j];
                        e.bv[j] = 1'b1;
                    end
                end
            end
            exp_q.push_back(e);
        end
    endfunction

    task automatic load(input int n, input bit bubbly, input int stray);
        int idx = 0, cyc = 0, poked = 0;
        while (idx < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (poked == 1) begin
                start_r = 1'b0;
                check("stray_start_load", 64'(ctl), 64'd0);
                poked = 2;
            end
            if (ordy && (!bubbly || (cyc % 2 == 1))) begin
                in_v    = 1'b1;
                in_data = stream[idx];
                if (idx < R*KK) am[idx] = stream[idx];
                else            bm[idx - R*KK] = stream[idx];
                idx++;
            end else begin
                in_v = 1'b0;
            end
            if (idx == stray && poked == 0) begin
                start_r = 1'b1;
                poked   = 1;
            end
        end
        @(negedge clk);
        in_v    = 1'b0;
        start_r = 1'b0;
        check("load_count", 64'(idx), 64'(n));
        check("loaded_ready", 64'(ordy), 64'd0);
        check("loaded_ctl", 64'(ctl), 64'd0);
    endtask

    // abort: 0 none, 1 rst_n pulse at t=3, 2 clear at t=3
    task automatic run(input bit keep, input bit poke, input int abort);
        int    t_feed = KK + ((R > C) ? R : C) - 1;
        int    saw;
        feed_t e;
        @(negedge clk);
        start_r = 1'b1;
        keep_b  = keep;
        push_expect();
        @(negedge clk);
        start_r = 1'b0;
        keep_b  = 1'b0;
        check("clr_ctl", 64'(ctl), 64'(3'b101));
        for (int cyc = 2; cyc < 2 + t_feed + D; cyc++) begin
            @(negedge clk);
            start_r = poke && (cyc == 4);
            e = exp_q.pop_front();
            check("feed_a", oa, e.a);
            check("feed_av", 64'(oav), 64'(e.av));
            check("feed_b", ob, e.b);
            check("feed_bv", 64'(obv), 64'(e.bv));
            check("feed_ctl", 64'(ctl), 64'(3'b001));
            if (abort != 0 && cyc == 5) begin
                if (abort == 1) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_ready", 64'(ordy), 64'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    clear = 1'b1;
                    @(negedge clk);
                    clear = 1'b0;
                end
                check("abort_a", oa | ob, 64'd0);
                check("abort_v", 64'({oav, obv}), 64'd0);
                check("abort_ctl", 64'(ctl), 64'd0);
                exp_q.delete();
                saw = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (ctl[1]) saw = 1;
                end
                check("abort_no_done", 64'(saw), 64'd0);
                check("abort_ready", 64'(ordy), 64'd1);
                return;
            end
        end
        @(negedge clk);
        check("done_ctl", 64'(ctl), 64'(3'b010));
        @(negedge clk);
        check("after_done_ctl", 64'(ctl), 64'd0);
        check("after_done_ready", 64'(ordy), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_v = 1'b0; start_r = 1'b0;
        keep_b = 1'b0; sel = 1'b0; in_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_data", oa | ob, 64'd0);
        check("rst_ctl", 64'({ordy, ctl, oav, obv}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(ordy), 64'd1);

        // A = 1..16, B = identity, continuous stream
        for (int i = 0; i < 16; i++) stream[i] = 8'(i + 1);
        for (int m = 0; m < 16; m++) stream[16 + m] = ((m / 4) == (m % 4)) ? 8'd1 : 8'd0;
        load(32, 1'b0, -1);
        in_v = 1'b1; in_data = 8'hEE;
        repeat (3) @(negedge clk);
        in_v = 1'b0;
        check("loaded_hold", 64'(ordy), 64'd0);
        run(1'b0, 1'b0, 0);

        // bubbly load, stray starts in LOAD and FEED, keep B for the next load
        load(32, 1'b1, 10);
        run(1'b1, 1'b1, 0);

        // only A is reloaded; B must replay unchanged
        for (int i = 0; i < 16; i++) stream[i] = 8'(2 * (i + 1));
        load(16, 1'b0, -1);
        run(1'b0, 1'b0, 0);

        for (int i = 0; i < 32; i++) stream[i] = 8'(i * 7 + 3);
        load(32, 1'b0, -1);
        run(1'b0, 1'b0, 1);
        load(32, 1'b0, -1);
        run(1'b0, 1'b0, 2);
        load(32, 1'b0, -1);
        run(1'b0, 1'b0, 0);

        // 2x3 array, K=5
        sel = 1'b1; R = 2; C = 3; KK = 5;
        for (int i = 0; i < 25; i++) stream[i] = 8'(i * 3 + 1);
        load(25, 1'b0, -1);
        run(1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Synthesizable operand loader and skew generator for a parametrised ROWS x COLS output-stationary systolic array.
- Accepts a single serial stream holding matrix A (ROWS x K) followed by matrix B (K x COLS). Buffers both locally.
- On start, drives the array's west edge (A rows) and north edge (B columns) with diagonally skewed, zero-padded operands, then signals done.
- Replaces the ad-hoc feed counter in the bench and adds weight (B) reuse across runs.

Parameters:
DATA_WIDTH, 8, operand width in bits
ROWS, 4, array rows = rows of A
COLS, 4, array columns = columns of B
K, 4, inner dimension (columns of A, rows of B)
DRAIN_CYCLES, 8, cycles after the last feed cycle before done (array pipeline flush)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; returns to LOAD and discards buffered data
in_valid  in  1  stream element valid
in_ready  out  1  feeder can accept an element
in_data  in  DATA_WIDTH  stream element
start  in  1  begin a feed run (honoured only in LOADED)
keep_b  in  1  sampled with an accepted start; next load skips B
busy  out  1  high in CLR, FEED and DRAIN
acc_clear  out  1  one-cycle pulse telling the array to zero its accumulators
a_out  out  ROWS*DATA_WIDTH  row i is in bits [i*DW +: DW]
a_valid  out  ROWS  per-row operand valid
b_out  out  COLS*DATA_WIDTH  column j is in bits [j*DW +: DW]
b_valid  out  COLS  per-column operand valid
done  out  1  one-cycle pulse at the end of the run

Behaviour:
- Reset is asynchronous: all outputs go to 0, state = LOAD, load counter = 0, the keep_b flag = 0, and the buffers are not cleared.
- States: LOAD, LOADED, CLR, FEED, DRAIN, DONE.
- LOAD:
  - in_ready = 1. An element transfers when in_valid && in_ready.
  - Element n < ROWS*K is written to A[n/K][n%K] (row-major).
  - The next K*COLS elements are written to B[m/COLS][m%COLS], where m = n - ROWS*K.
  - If the keep_b flag is set, the load length is ROWS*K only and B is preserved.
  - Gaps in in_valid are allowed. On the transfer of the last element, go to LOADED on the next edge.
- LOADED: in_ready = 0. start goes to CLR and latches keep_b into the flag. start in any other state is ignored.
- CLR: acc_clear = 1 for exactly one cycle, then go to FEED with t = 0.
- FEED lasts T = K + max(ROWS,COLS) - 1 cycles, t = 0..T-1. Outputs are registered and change on the edge that enters each t.
  - Row i: if 0 <= t-i < K, then a_out_i = A[i][t-i] and a_valid[i] = 1. Otherwise a_out_i = 0 and a_valid[i] = 0.
  - Column j: if 0 <= t-j < K, then b_out_j = B[t-j][j] and b_valid[j] = 1. Otherwise both are 0.
- DRAIN: all a/b outputs and valids = 0 for DRAIN_CYCLES cycles.
- DONE: done = 1 for one cycle, then go to LOAD with the counter = 0. busy = 0 in DONE.
- Latency: from the start-sample edge, acc_clear is high in cycle 1, t = 0 in cycle 2, and done is in cycle 2 + T + DRAIN_CYCLES.
- clear has priority over every other input. From any state it goes to LOAD with the counter = 0 and the flag = 0. Outputs go to 0 and no done is issued.
- in_valid outside LOAD is ignored and not stored.
- Widths: the load counter is clog2(ROWS*K+K*COLS+1) bits. The phase counter is clog2(max(T,DRAIN_CYCLES)+1) bits. No arithmetic is performed on data.

Test Plan:
- Defaults; stream A = 1..16, then B = identity (1,0,0,0,0,1,...), with in_valid continuous -> LOADED after 32 transfers, in_ready drops; start -> acc_clear 1 cycle; at t=0 a_out row0 = 1, a_valid = 4'b0001, b_valid = 4'b0001; at t=1 row1 = 5; at t=6 only row3 = 16 is valid; done 2+7+8 = 17 cycles after start.
- Bubbly load: in_valid toggles every other cycle -> same 32 stored values; FEED outputs are identical to the first scenario.
- start asserted during LOAD (after 10 elements) and during FEED -> ignored; no state change and no second acc_clear.
- keep_b=1 on start; after done, load A = 16 new values (2,4,...,32) -> LOADED after exactly 16 transfers; the next run's b_out sequence equals the prior run's.
- rst_n pulsed low at t=3 of FEED -> all outputs 0 immediately, state LOAD, in_ready = 1 after release, no done. Repeat with clear at the same point -> same result, synchronous.
- ROWS=2, COLS=3, K=5 -> T = 7; column 2 is valid for t = 2..6; row 1 is valid for t = 1..5; done 2+7+8 cycles after start.
